// File: rtl/bsg_manycore_proc_endpoint_if.sv
// rtl/bsg_manycore_proc_endpoint_if.sv - signal bundle for the manycore proc endpoint links and tile port
interface bsg_manycore_proc_endpoint_if #(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 5,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 16,
    parameter int max_out_credits_p = 16,
    localparam int packet_width_lp  = addr_width_p + 2 + (data_width_p/8) + data_width_p
                                      + 2*(x_cord_width_p + y_cord_width_p),
    localparam int return_width_lp  = y_cord_width_p + x_cord_width_p,
    localparam int cw_lp            = $clog2(max_out_credits_p + 1)
) ();
    logic                       link_fwd_v;
    logic [packet_width_lp-1:0] link_fwd_data;
    logic                       link_fwd_ready;
    logic                       link_rev_v;
    logic [return_width_lp-1:0] link_rev_data;
    logic                       link_rev_ready;
    logic                       out_fwd_v;
    logic [packet_width_lp-1:0] out_fwd_data;
    logic                       out_fwd_ready;
    logic                       out_rev_v;
    logic [return_width_lp-1:0] out_rev_data;
    logic                       out_rev_ready;
    logic                       in_v;
    logic [addr_width_p-1:0]    in_addr;
    logic [data_width_p-1:0]    in_data;
    logic [data_width_p/8-1:0]  in_mask;
    logic [1:0]                 in_op;
    logic                       in_yumi;
    logic                       req_v;
    logic [packet_width_lp-1:0] req_data;
    logic                       req_ready;
    logic [cw_lp-1:0]           out_credits;
    logic                       credit_err;

    // master drives the endpoint's inputs (mesh node + tile side)
    modport master (
        output link_fwd_v, link_fwd_data, link_rev_ready, out_fwd_ready,
               out_rev_v, out_rev_data, in_yumi, req_v, req_data,
        input  link_fwd_ready, link_rev_v, link_rev_data, out_fwd_v, out_fwd_data,
               out_rev_ready, in_v, in_addr, in_data, in_mask, in_op, req_ready,
               out_credits, credit_err
    );

    modport slave (
        input  link_fwd_v, link_fwd_data, link_rev_ready, out_fwd_ready,
               out_rev_v, out_rev_data, in_yumi, req_v, req_data,
        output link_fwd_ready, link_rev_v, link_rev_data, out_fwd_v, out_fwd_data,
               out_rev_ready, in_v, in_addr, in_data, in_mask, in_op, req_ready,
               out_credits, credit_err
    );
endinterface

// File: rtl/bsg_manycore_proc_endpoint.sv
// rtl/bsg_manycore_proc_endpoint.sv - tile endpoint: inbound request FIFO, return issue, outbound credit gating
// Optional statistics counters enabled by BSG_MANYCORE_ENDPOINT_STATS_EN.
module bsg_manycore_proc_endpoint #(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 5,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 16,
    parameter int fifo_els_p        = 4,
    parameter int max_out_credits_p = 16,
    localparam int packet_width_lp  = addr_width_p + 2 + (data_width_p/8) + data_width_p
                                      + 2*(x_cord_width_p + y_cord_width_p),
    localparam int return_width_lp  = y_cord_width_p + x_cord_width_p,
    localparam int cw_lp            = $clog2(max_out_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       link_fwd_v_i,
    input  logic [packet_width_lp-1:0] link_fwd_data_i,
    output logic                       link_fwd_ready_o,

    output logic                       link_rev_v_o,
    output logic [return_width_lp-1:0] link_rev_data_o,
    input  logic                       link_rev_ready_i,

    output logic                       out_fwd_v_o,
    output logic [packet_width_lp-1:0] out_fwd_data_o,
    input  logic                       out_fwd_ready_i,

    input  logic                       out_rev_v_i,
    input  logic [return_width_lp-1:0] out_rev_data_i,
    output logic                       out_rev_ready_o,

    output logic                       in_v_o,
    output logic [addr_width_p-1:0]    in_addr_o,
    output logic [data_width_p-1:0]    in_data_o,
    output logic [data_width_p/8-1:0]  in_mask_o,
    output logic [1:0]                 in_op_o,
    input  logic                       in_yumi_i,

    input  logic                       req_v_i,
    input  logic [packet_width_lp-1:0] req_data_i,
    output logic                       req_ready_o,

    output logic [cw_lp-1:0]           out_credits_o,
    output logic                       credit_err_o
`ifdef BSG_MANYCORE_ENDPOINT_STATS_EN
    ,
    output logic [31:0]                stat_rx_o,
    output logic [31:0]                stat_stall_o
`endif
);
    localparam int ptr_w_lp   = $clog2(fifo_els_p);
    localparam int cnt_w_lp   = $clog2(fifo_els_p + 1);
    localparam int src_lo_lp  = x_cord_width_p + y_cord_width_p;
    localparam int data_lo_lp = 2*(x_cord_width_p + y_cord_width_p);
    localparam int mask_lo_lp = data_lo_lp + data_width_p;
    localparam int op_lo_lp   = mask_lo_lp + data_width_p/8;
    localparam int addr_lo_lp = op_lo_lp + 2;

    logic [packet_width_lp-1:0] mem_q [fifo_els_p];
    logic [packet_width_lp-1:0] mem_d [fifo_els_p];
    logic [ptr_w_lp-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]        cnt_q, cnt_d;

    logic [return_width_lp-1:0] ret_mem_q [2];
    logic [return_width_lp-1:0] ret_mem_d [2];
    logic                       ret_wr_q, ret_wr_d, ret_rd_q, ret_rd_d;
    logic [1:0]                 ret_cnt_q, ret_cnt_d;

    logic [cw_lp-1:0]           credits_q, credits_d;
    logic                       err_q, err_d;

    logic                       fifo_full, fifo_empty, ret_full;
    logic                       fifo_enq, fifo_deq, ret_deq;
    logic                       credits_nz, send, ret_in;
    logic [packet_width_lp-1:0] head;

    assign fifo_full  = (cnt_q == cnt_w_lp'(fifo_els_p));
    assign fifo_empty = (cnt_q == '0);
    assign ret_full   = (ret_cnt_q == 2'd2);
    assign head       = mem_q[rd_ptr_q];

    assign link_fwd_ready_o = ~fifo_full;
    assign in_v_o           = ~fifo_empty & ~ret_full;
    assign in_addr_o        = head[addr_lo_lp +: addr_width_p];
    assign in_op_o          = head[op_lo_lp +: 2];
    assign in_mask_o        = head[mask_lo_lp +: data_width_p/8];
    assign in_data_o        = head[data_lo_lp +: data_width_p];

    assign link_rev_v_o     = (ret_cnt_q != 2'd0);
    assign link_rev_data_o  = ret_mem_q[ret_rd_q];

    assign credits_nz       = (credits_q != '0);
    assign out_fwd_data_o   = req_data_i;
    assign out_fwd_v_o      = req_v_i & credits_nz;
    assign req_ready_o      = out_fwd_ready_i & credits_nz;
    assign out_rev_ready_o  = 1'b1;
    assign out_credits_o    = credits_q;
    assign credit_err_o     = err_q;

    // a yumi without in_v_o is dropped here so it can never pop an empty FIFO
    assign fifo_enq = link_fwd_v_i & link_fwd_ready_o;
    assign fifo_deq = in_yumi_i & in_v_o;
    assign ret_deq  = link_rev_v_o & link_rev_ready_i;
    assign send     = out_fwd_v_o & out_fwd_ready_i;
    assign ret_in   = out_rev_v_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (fifo_enq) begin
            mem_d[wr_ptr_q] = link_fwd_data_i;
            wr_ptr_d = (wr_ptr_q == ptr_w_lp'(fifo_els_p-1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (fifo_deq) begin
            rd_ptr_d = (rd_ptr_q == ptr_w_lp'(fifo_els_p-1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (fifo_enq & ~fifo_deq)      cnt_d = cnt_q + 1'b1;
        else if (~fifo_enq & fifo_deq) cnt_d = cnt_q - 1'b1;
    end

    // return entry is the consumed head's source coordinates {src_y, src_x}
    always_comb begin
        ret_mem_d = ret_mem_q;
        ret_wr_d  = ret_wr_q;
        ret_rd_d  = ret_rd_q;
        ret_cnt_d = ret_cnt_q;
        if (fifo_deq) begin
            ret_mem_d[ret_wr_q] = head[data_lo_lp-1:src_lo_lp];
            ret_wr_d = ~ret_wr_q;
        end
        if (ret_deq) ret_rd_d = ~ret_rd_q;
        if (fifo_deq & ~ret_deq)      ret_cnt_d = ret_cnt_q + 2'd1;
        else if (~fifo_deq & ret_deq) ret_cnt_d = ret_cnt_q - 2'd1;
    end

    // a return with no matching outstanding request is an overflow: hold count, flag sticky error
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (send & ~ret_in) begin
            credits_d = credits_q - 1'b1;
        end else if (ret_in & ~send) begin
            if (credits_q == cw_lp'(max_out_credits_p)) err_d = 1'b1;
            else                                         credits_d = credits_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q     <= mem_d;
        ret_mem_q <= ret_mem_d;
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ret_wr_q  <= 1'b0;
            ret_rd_q  <= 1'b0;
            ret_cnt_q <= 2'd0;
            credits_q <= cw_lp'(max_out_credits_p);
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ret_wr_q  <= ret_wr_d;
            ret_rd_q  <= ret_rd_d;
            ret_cnt_q <= ret_cnt_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

`ifdef BSG_MANYCORE_ENDPOINT_STATS_EN
    logic [31:0] stat_rx_q, stat_rx_d, stat_stall_q, stat_stall_d;

    always_comb begin
        stat_rx_d    = stat_rx_q + {31'd0, fifo_deq};
        stat_stall_d = stat_stall_q + {31'd0, req_v_i & ~credits_nz};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_rx_q    <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_rx_q    <= stat_rx_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_rx_o    = stat_rx_q;
    assign stat_stall_o = stat_stall_q;
`endif

    illegal_yumi_a: assert property (@(posedge clk_i) disable iff (reset_i) in_yumi_i |-> in_v_o);
endmodule
